// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divider-chain clock monitor.
package clk_mon_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam logic [7:0]  ERR_MAX       = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } mon_state_e;

endpackage

// File: rtl/clk_mon_edge.sv
// Two-flop synchronizer plus delay flop; flags the first synchronized-high cycle.
module clk_mon_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise
);

  logic sync1_q, sync2_q, dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign sig_s = sync2_q;
  assign rise  = sync2_q & ~dly_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divider output in clk cycles and
// checks them against programmed expectations, tracking lock and errors.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             mismatch,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam logic [MatchW-1:0] LockMax = MatchW'(LOCK_COUNT);

  mon_state_e        state_q;
  logic [CNT_W-1:0]  period_cnt_q, high_cnt_q;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic              sig_s, rise, is_match;

  clk_mon_edge u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise)
  );

  always_comb begin
    is_match    = (period_cnt_q == exp_period) && (high_cnt_q == exp_high);
    match_cnt_d = (match_cnt_q == LockMax) ? LockMax : match_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      match_cnt_q  <= '0;
      meas_valid   <= 1'b0;
      mismatch     <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      locked       <= 1'b0;
      err_count    <= '0;
    end else begin
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      if (!en) begin
        state_q      <= StIdle;
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        match_cnt_q  <= '0;
        locked       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            // The arming rise only starts the counters; it is not a measurement.
            if (rise) begin
              state_q      <= StMeasure;
              period_cnt_q <= CNT_W'(1);
              high_cnt_q   <= CNT_W'(1);
            end
          end
          StMeasure: begin
            if (rise) begin
              meas_valid   <= 1'b1;
              period       <= period_cnt_q;
              high_time    <= high_cnt_q;
              period_cnt_q <= CNT_W'(1);
              high_cnt_q   <= CNT_W'(1);
              if (is_match) begin
                match_cnt_q <= match_cnt_d;
                if (match_cnt_d == LockMax) locked <= 1'b1;
              end else begin
                mismatch    <= 1'b1;
                match_cnt_q <= '0;
                locked      <= 1'b0;
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
              end
            end else if (period_cnt_q == '1) begin
              // No rise before the counter saturates: report and re-arm.
              state_q      <= StArm;
              mismatch     <= 1'b1;
              locked       <= 1'b0;
              match_cnt_q  <= '0;
              period_cnt_q <= '0;
              high_cnt_q   <= '0;
              if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            end else begin
              period_cnt_q <= period_cnt_q + 1'b1;
              if (sig_s) high_cnt_q <= high_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: stimulus pushes expected results,
// a negedge monitor pops and compares on every meas_valid/mismatch pulse.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  logic       clk, reset, sig_in, en;
  logic [7:0] exp_period, exp_high;
  logic       meas_valid, mismatch, locked;
  logic [7:0] period, high_time, err_count;

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;

  typedef struct packed {
    logic       valid;
    logic [7:0] per;
    logic [7:0] hi;
    logic       mism;
    logic       lck;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];

  clk_div_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .en         (en),
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .meas_valid (meas_valid),
    .period     (period),
    .high_time  (high_time),
    .mismatch   (mismatch),
    .locked     (locked),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic v, input int p, input int h, input logic m,
                      input logic l, input int e);
    exp_t x;
    x.valid = v;
    x.per   = 8'(p);
    x.hi    = 8'(h);
    x.mism  = m;
    x.lck   = l;
    x.err   = 8'(e);
    sb.push_back(x);
  endtask

  // Drives one bit per clk from pat (bit 0 first), reps times over.
  task automatic drive(input logic [15:0] pat, input int len, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < len; i++) begin
        sig_in = pat[i];
        @(posedge clk);
        #1;
      end
    end
    sig_in = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart_en;
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    cycles(3);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (meas_valid || mismatch)) begin
        pulses_seen++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("meas_valid", int'(meas_valid), int'(e.valid));
          check("mismatch", int'(mismatch), int'(e.mism));
          check("period", int'(period), int'(e.per));
          check("high_time", int'(high_time), int'(e.hi));
          check("locked", int'(locked), int'(e.lck));
          check("err_count", int'(err_count), int'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1; sig_in = 1'b0; en = 1'b0; exp_period = 8'd2; exp_high = 8'd1;
    cycles(3);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_period", int'(period), 0);
    reset = 1'b0;
    en = 1'b1;
    cycles(3);

    // div2, exp 2/1: lock on the 4th measurement
    for (int i = 0; i < 9; i++) push(1, 2, 1, 0, i >= 3, 0);
    drive(16'h0001, 2, 10);
    cycles(6);
    check("drain_div2", sb.size(), 0);
    en = 1'b0;
    cycles(2);
    check("en_low_locked", int'(locked), 0);
    check("en_low_period_hold", int'(period), 2);

    // div16, exp 16/8
    exp_period = 8'd16; exp_high = 8'd8;
    en = 1'b1;
    cycles(3);
    for (int i = 0; i < 5; i++) push(1, 16, 8, 0, i >= 3, 0);
    drive(16'h00FF, 16, 6);
    cycles(6);
    check("drain_div16", sb.size(), 0);

    // Y = div2 & div8, exp 8/1: periods alternate 2/6, every one mismatches
    exp_period = 8'd8; exp_high = 8'd1;
    restart_en();
    for (int i = 0; i < 7; i++) push(1, (i % 2 == 0) ? 2 : 6, 1, 1, 0, i + 1);
    drive(16'h0005, 8, 4);
    cycles(6);
    check("drain_y", sb.size(), 0);

    // div4 lock, then hold low for a timeout
    exp_period = 8'd4; exp_high = 8'd2;
    restart_en();
    for (int i = 0; i < 5; i++) push(1, 4, 2, 0, i >= 3, 7);
    push(0, 4, 2, 1, 0, 8);
    drive(16'h0003, 4, 6);
    cycles(300);
    check("drain_timeout", sb.size(), 0);
    check("timeout_state_arm", int'(dut.state_q), int'(StArm));

    // Re-lock on div4, then reset mid-period
    for (int i = 0; i < 5; i++) push(1, 4, 2, 0, i >= 3, 8);
    drive(16'h0003, 4, 6);
    cycles(6);
    check("drain_relock", sb.size(), 0);
    check("locked_before_reset", int'(locked), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_locked", int'(locked), 0);
    check("rst_async_err", int'(err_count), 0);
    check("rst_async_period", int'(period), 0);
    check("rst_async_high", int'(high_time), 0);
    check("rst_async_valid", int'(meas_valid), 0);
    check("rst_async_mismatch", int'(mismatch), 0);
    cycles(2);
    reset = 1'b0;
    cycles(3);
    p0 = pulses_seen;
    drive(16'h0003, 4, 1);
    cycles(8);
    check("first_rise_arms_only", pulses_seen - p0, 0);

    // 300 mismatching measurements: err_count saturates at 255
    exp_period = 8'd3; exp_high = 8'd1;
    restart_en();
    for (int i = 0; i < 300; i++) push(1, 2, 1, 1, 0, (i + 1 > 255) ? 255 : i + 1);
    drive(16'h0001, 2, 301);
    cycles(6);
    check("drain_sat", sb.size(), 0);
    check("err_saturated", int'(err_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
